// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: valid/ready word in, framed serial bit stream out, timed by a fractional baud NCO.
// Optional UART_TX_TWO_STOP_BITS_EN adds a second stop bit. control_0: [3:0] data_bits, [4] parity_bit, [5] odd_parity.
module uart_tx_serializer #(
  parameter int unsigned CLK_FREQ_HZ   = 50_000_000,
  parameter int unsigned MAX_DATA_BITS = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              baud_rate_csr,
  input  logic [31:0]              control_0_csr,
  input  logic [MAX_DATA_BITS-1:0] tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic                     tx,
  output logic [31:0]              status_0
);

  localparam logic [32:0] CLK_F  = 33'(CLK_FREQ_HZ);
  localparam logic [3:0]  MAX_DB = 4'(MAX_DATA_BITS);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                   state_q, state_d;
  logic [32:0]              acc_q, acc_d;
  logic [3:0]               bit_cnt_q, bit_cnt_d;
  logic                     err_q, err_d;
  logic [MAX_DATA_BITS-1:0] data_q;
  logic [3:0]               nbits_q;
  logic                     par_en_q, odd_q;
  logic [31:0]              baud_q;
`ifdef UART_TX_TWO_STOP_BITS_EN
  logic                     stop_cnt_q, stop_cnt_d;
`endif

  logic [3:0]               db_w;
  logic                     par_w, odd_w, legal_w, start_w, tick_w, busy_w;
  logic [32:0]              sum_w;
  logic [MAX_DATA_BITS-1:0] masked_w;
  logic                     unused_csr_bits;

  function automatic logic parity_of(input logic [MAX_DATA_BITS-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  assign db_w            = control_0_csr[3:0];
  assign par_w           = control_0_csr[4];
  assign odd_w           = control_0_csr[5];
  assign unused_csr_bits = ^control_0_csr[31:6];

  assign tx_ready = (state_q == S_IDLE) && !rst && (baud_rate_csr != 32'd0)
                    && ({1'b0, baud_rate_csr} <= CLK_F);
  assign legal_w  = (db_w >= 4'd5) && (db_w <= MAX_DB);
  assign start_w  = tx_valid && tx_ready && legal_w;
  assign sum_w    = acc_q + {1'b0, baud_q};
  assign tick_w   = (sum_w >= CLK_F);

  // Only the low data_bits bits take part in the frame and in parity.
  always_comb begin
    masked_w = '0;
    for (int i = 0; i < MAX_DATA_BITS; i++) begin
      if (4'(i) < db_w) masked_w[i] = tx_data[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      bit_cnt_q <= '0;
      err_q     <= 1'b0;
`ifdef UART_TX_TWO_STOP_BITS_EN
      stop_cnt_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      bit_cnt_q <= bit_cnt_d;
      err_q     <= err_d;
`ifdef UART_TX_TWO_STOP_BITS_EN
      stop_cnt_q <= stop_cnt_d;
`endif
    end
  end

  // Frame configuration is frozen at accept so CSR writes mid-frame are ignored.
  always_ff @(posedge clk) begin
    if (start_w) begin
      data_q   <= masked_w;
      nbits_q  <= db_w;
      par_en_q <= par_w;
      odd_q    <= odd_w;
      baud_q   <= baud_rate_csr;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    bit_cnt_d = bit_cnt_q;
    err_d     = err_q;
`ifdef UART_TX_TWO_STOP_BITS_EN
    stop_cnt_d = stop_cnt_q;
`endif
    if (state_q != S_IDLE) acc_d = tick_w ? (sum_w - CLK_F) : sum_w;
    case (state_q)
      S_IDLE: begin
        if (tx_valid && tx_ready) begin
          if (legal_w) begin
            state_d   = S_START;
            acc_d     = '0;
            bit_cnt_d = '0;
            err_d     = 1'b0;
`ifdef UART_TX_TWO_STOP_BITS_EN
            stop_cnt_d = 1'b0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_START:  if (tick_w) state_d = S_DATA;
      S_DATA: begin
        if (tick_w) begin
          if (bit_cnt_q == nbits_q - 4'd1) state_d = par_en_q ? S_PARITY : S_STOP;
          else bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      S_PARITY: if (tick_w) state_d = S_STOP;
      S_STOP: begin
`ifdef UART_TX_TWO_STOP_BITS_EN
        if (tick_w) begin
          if (!stop_cnt_q) stop_cnt_d = 1'b1;
          else state_d = S_IDLE;
        end
`else
        if (tick_w) state_d = S_IDLE;
`endif
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx     = 1'b1;
    busy_w = 1'b1;
    case (state_q)
      S_IDLE:   busy_w = 1'b0;
      S_START:  tx = 1'b0;
      S_DATA:   tx = data_q[bit_cnt_q];
      S_PARITY: tx = parity_of(data_q, odd_q);
      default:  tx = 1'b1;
    endcase
  end

  // status_0: [0] busy, [1] data_bits_error, [2] parity_error (receive side, always 0).
  assign status_0 = {29'd0, 1'b0, err_q, busy_w};

endmodule
